// File: rtl/ssb_pkg.sv
// Constants and helpers shared by the SSB modulator and demodulator.
package ssb_pkg;

    localparam int PHASE_W    = 18;
    localparam int OFFSET_W   = 14;
    localparam int LUT_ADDR_W = 10;
    localparam int LUT_DATA_W = 16;
    localparam int LEVEL_W    = 24;

    typedef logic [PHASE_W-1:0]    phase_t;
    typedef logic [LUT_ADDR_W-1:0] lut_addr_t;

    // Table address: accumulator plus the coarse offset (offset sits 4 bits above the LSB).
    function automatic lut_addr_t phase_to_addr(input phase_t acc, input logic [OFFSET_W-1:0] offset);
        return lut_addr_t'((acc + {offset, 4'b0000}) >> (PHASE_W - LUT_ADDR_W));
    endfunction

endpackage

// File: rtl/ssb_cos_lut.sv
// Cosine lookup: quarter-wave table folded by quadrant, one registered cycle of latency.
module ssb_cos_lut
    import ssb_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LUT_ADDR_W-1:0]        addr,
    output logic signed [LUT_DATA_W-1:0] cos_val
);

    localparam int IDX_W = LUT_ADDR_W - 2;
    localparam int QTR   = 1 << IDX_W;

    function automatic logic [LUT_DATA_W-1:0] quarter_cos(input int idx);
        real ang;
        ang = 2.0 * 3.14159265358979324 * real'(idx) / real'(4 * QTR);
        return LUT_DATA_W'($rtoi(32767.0 * $cos(ang) + 0.5));
    endfunction

    // Entry QTR holds cos(pi/2) so the quadrant edges fold to an exact zero.
    logic [LUT_DATA_W-1:0] quarter_s [0:QTR];
    for (genvar g = 0; g <= QTR; g++) begin : g_quarter
        assign quarter_s[g] = quarter_cos(g);
    end

    logic [IDX_W:0]        idx_s;
    logic [LUT_DATA_W-1:0] mag_s;
    logic                  neg_s;

    // Odd quadrants read the table backwards; quadrants 1 and 2 are negative.
    always_comb begin
        idx_s = {1'b0, addr[IDX_W-1:0]};
        if (addr[IDX_W]) begin
            idx_s = (IDX_W+1)'(QTR) - {1'b0, addr[IDX_W-1:0]};
        end else begin
            idx_s = {1'b0, addr[IDX_W-1:0]};
        end
        mag_s = quarter_s[idx_s];
        neg_s = addr[LUT_ADDR_W-1] ^ addr[IDX_W];
    end

    // Registered, sign-applied table output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cos_val <= '0;
        end else if (neg_s) begin
            cos_val <= -mag_s;
        end else begin
            cos_val <= mag_s;
        end
    end

endmodule

// File: rtl/ssb_demodulator.sv
// SSB product detector: NCO cosine mix, integrate-and-dump decimation, peak/decay level meter.
module ssb_demodulator
    import ssb_pkg::*;
#(
    parameter int DEC_LOG2 = 6,
    parameter int DATA_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     in_valid,
    input  logic [PHASE_W-1:0]       ssb_freq,
    input  logic [OFFSET_W-1:0]      delta_phase,
    input  logic                     stdby,
    output logic signed [DATA_W-1:0] audio_out,
    output logic                     out_valid,
    output logic [LEVEL_W-1:0]       level
);

    localparam int PROD_W = DATA_W + LUT_DATA_W;
    localparam int ACC_W  = PROD_W + DEC_LOG2;
    localparam int SHIFT  = 15 + DEC_LOG2;
    localparam int SCL_W  = ACC_W - SHIFT;
    localparam int CMP_W  = (DATA_W + 9 > LEVEL_W) ? DATA_W + 9 : LEVEL_W;

    phase_t                      phase_acc_r;
    lut_addr_t                   addr_r;
    logic [DEC_LOG2-1:0]         cnt_r;
    logic signed [DATA_W-1:0]    samp1_r;
    logic signed [DATA_W-1:0]    samp2_r;
    logic                        v1_r, v2_r, v3_r;
    logic                        last1_r, last2_r, last3_r;
    logic signed [LUT_DATA_W-1:0] cos_s;
    logic signed [PROD_W-1:0]    prod_r;
    logic signed [ACC_W-1:0]     acc_r;
    logic signed [ACC_W-1:0]     acc_sum_s;
    logic signed [SCL_W-1:0]     scaled_s;
    logic signed [DATA_W-1:0]    sat_s;
    logic signed [DATA_W:0]      sat_ext_s;
    logic [DATA_W:0]             mag_s;
    logic [CMP_W-1:0]            mag_sh_s;
    logic [CMP_W-1:0]            level_ext_s;
    logic [LEVEL_W-1:0]          level_next_s;
    logic signed [DATA_W-1:0]    audio_r;
    logic                        out_valid_r;
    logic [LEVEL_W-1:0]          level_r;

    // Sample acceptance: NCO step, table address, block position tag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_acc_r <= '0;
            addr_r      <= '0;
            samp1_r     <= '0;
            cnt_r       <= '0;
            v1_r        <= 1'b0;
            last1_r     <= 1'b0;
        end else if (stdby) begin
            cnt_r <= '0;
            v1_r  <= 1'b0;
        end else if (in_valid) begin
            phase_acc_r <= phase_acc_r + ssb_freq;
            addr_r      <= phase_to_addr(phase_acc_r, delta_phase);
            samp1_r     <= sample_in;
            cnt_r       <= cnt_r + DEC_LOG2'(1);
            v1_r        <= 1'b1;
            last1_r     <= (cnt_r == {DEC_LOG2{1'b1}});
        end else begin
            v1_r <= 1'b0;
        end
    end

    ssb_cos_lut u_cos_lut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr_r),
        .cos_val (cos_s)
    );

    // Sample delay alongside the table read, then the full-width mix product.
    always_ff @(posedge clk) begin
        if (!rst) begin
            samp2_r <= '0;
            v2_r    <= 1'b0;
            last2_r <= 1'b0;
            prod_r  <= '0;
            v3_r    <= 1'b0;
            last3_r <= 1'b0;
        end else if (stdby) begin
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            samp2_r <= samp1_r;
            v2_r    <= v1_r;
            last2_r <= last1_r;
            prod_r  <= PROD_W'(cos_s) * PROD_W'(samp2_r);
            v3_r    <= v2_r;
            last3_r <= last2_r;
        end
    end

    // Block sum scaled back to audio range, saturated, and fed to the level meter.
    always_comb begin
        acc_sum_s = acc_r + ACC_W'(prod_r);
        scaled_s  = SCL_W'(acc_sum_s >>> SHIFT);
        if (scaled_s[SCL_W-1] != scaled_s[SCL_W-2]) begin
            sat_s = scaled_s[SCL_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_s = scaled_s[DATA_W-1:0];
        end
        sat_ext_s   = {sat_s[DATA_W-1], sat_s};
        mag_s       = sat_ext_s[DATA_W] ? -sat_ext_s : sat_ext_s;
        mag_sh_s    = CMP_W'(mag_s) << 4'd8;
        level_ext_s = CMP_W'(level_r);
        if (mag_sh_s > level_ext_s) begin
            level_next_s = LEVEL_W'(mag_sh_s);
        end else begin
            level_next_s = level_r - (level_r >> 4'd8);
        end
    end

    // Integrate-and-dump; the last product of a block goes straight to the output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r       <= '0;
            audio_r     <= '0;
            out_valid_r <= 1'b0;
            level_r     <= '0;
        end else if (stdby) begin
            acc_r       <= '0;
            audio_r     <= '0;
            out_valid_r <= 1'b0;
        end else if (v3_r && last3_r) begin
            acc_r       <= '0;
            audio_r     <= sat_s;
            out_valid_r <= 1'b1;
            level_r     <= level_next_s;
        end else if (v3_r) begin
            acc_r       <= acc_sum_s;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign audio_out = audio_r;
    assign out_valid = out_valid_r;
    assign level     = level_r;

endmodule
